// File: rtl/mult_div_seq.sv
// Sequential signed multiply/divide unit: radix-2 Booth multiply and restoring divide behind a busy/done handshake.
// Build option MULT_FAST_EN swaps the Booth loop for a single-cycle combinational multiplier.
module mult_div_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned AW = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;

  state_t             r_state, w_state_n;
  logic [AW-1:0]      r_acc, w_acc_n;       // Booth upper accumulator / divider remainder
  logic [WIDTH-1:0]   r_q, w_q_n;           // multiplier / dividend-then-quotient
  logic               r_qm1, w_qm1_n;
  logic [AW-1:0]      r_mcand, w_mcand_n;   // sign-extended multiplicand / zero-extended |divisor|
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic               r_sa, w_sa_n, r_sb, w_sb_n;
  logic [WIDTH-1:0]   r_hi, w_hi_n, r_lo, w_lo_n;
  logic               r_busy, w_busy_n, r_done, w_done_n, r_div_zero, w_div_zero_n;
  logic [AW-1:0]      w_sum, w_rem_sh, w_trial;

`ifdef MULT_FAST_EN
  logic signed [2*WIDTH-1:0] w_prod;
  assign w_prod = (2*WIDTH)'($signed(r_mcand[WIDTH-1:0])) * (2*WIDTH)'($signed(r_q));
`endif

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;

  // Next-state and datapath update
  always_comb begin
    w_state_n    = r_state;
    w_acc_n      = r_acc;
    w_q_n        = r_q;
    w_qm1_n      = r_qm1;
    w_mcand_n    = r_mcand;
    w_cnt_n      = r_cnt;
    w_sa_n       = r_sa;
    w_sb_n       = r_sb;
    w_hi_n       = r_hi;
    w_lo_n       = r_lo;
    w_div_zero_n = r_div_zero;
    w_sum        = '0;
    w_rem_sh     = '0;
    w_trial      = '0;

    case (r_state)
      S_IDLE: begin
        if (start_mult) begin
          w_mcand_n    = {a[WIDTH-1], a};
          w_q_n        = b;
          w_qm1_n      = 1'b0;
          w_acc_n      = '0;
          w_cnt_n      = '0;
          w_div_zero_n = 1'b0;
          w_state_n    = S_MULT;
        end else if (start_div) begin
          // b==0 still spends one cycle in DIV so done lands after edge 1
          w_div_zero_n = (b == '0);
          w_sa_n       = a[WIDTH-1];
          w_sb_n       = b[WIDTH-1];
          w_q_n        = a[WIDTH-1] ? -a : a;
          w_mcand_n    = {1'b0, (b[WIDTH-1] ? -b : b)};
          w_acc_n      = '0;
          w_cnt_n      = '0;
          w_state_n    = S_DIV;
        end
      end

`ifdef MULT_FAST_EN
      S_MULT: begin
        w_cnt_n = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_hi_n    = w_prod[2*WIDTH-1:WIDTH];
          w_lo_n    = w_prod[WIDTH-1:0];
          w_state_n = S_FINISH;
        end
      end
`else
      S_MULT: begin
        case ({r_q[0], r_qm1})
          2'b01:   w_sum = r_acc + r_mcand;
          2'b10:   w_sum = r_acc - r_mcand;
          default: w_sum = r_acc;
        endcase
        w_acc_n = {w_sum[WIDTH], w_sum[WIDTH:1]};
        w_q_n   = {w_sum[0], r_q[WIDTH-1:1]};
        w_qm1_n = r_q[0];
        w_cnt_n = r_cnt + CNT_W'(1);
        if (r_cnt == LAST) begin
          w_hi_n    = w_acc_n[WIDTH-1:0];
          w_lo_n    = w_q_n;
          w_state_n = S_FINISH;
        end
      end
`endif

      S_DIV: begin
        if (r_div_zero) begin
          w_state_n = S_FINISH;
        end else begin
          w_rem_sh = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
          w_trial  = w_rem_sh - r_mcand;
          if (!w_trial[WIDTH]) begin
            w_acc_n = w_trial;
            w_q_n   = {r_q[WIDTH-2:0], 1'b1};
          end else begin
            w_acc_n = w_rem_sh;
            w_q_n   = {r_q[WIDTH-2:0], 1'b0};
          end
          w_cnt_n = r_cnt + CNT_W'(1);
          // Truncating division: quotient sign from sign(a)^sign(b), remainder follows a
          if (r_cnt == LAST) begin
            w_lo_n    = (r_sa ^ r_sb) ? -w_q_n : w_q_n;
            w_hi_n    = r_sa ? -w_acc_n[WIDTH-1:0] : w_acc_n[WIDTH-1:0];
            w_state_n = S_FINISH;
          end
        end
      end

      S_FINISH: w_state_n = S_IDLE;

      default:  w_state_n = S_IDLE;
    endcase

    w_busy_n = (w_state_n != S_IDLE);
    w_done_n = (w_state_n == S_FINISH);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_q        <= '0;
      r_qm1      <= 1'b0;
      r_mcand    <= '0;
      r_cnt      <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_acc      <= w_acc_n;
      r_q        <= w_q_n;
      r_qm1      <= w_qm1_n;
      r_mcand    <= w_mcand_n;
      r_cnt      <= w_cnt_n;
      r_sa       <= w_sa_n;
      r_sb       <= w_sb_n;
      r_hi       <= w_hi_n;
      r_lo       <= w_lo_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_div_zero <= w_div_zero_n;
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: directed test-plan steps plus random ops against an arithmetic model.
module tb_mult_div_seq;

  localparam int unsigned W = 32;
`ifdef MULT_FAST_EN
  localparam int MULT_LAT = 2;
`else
  localparam int MULT_LAT = 32;
`endif
  localparam int DIV_LAT = 32;
  localparam int DZ_LAT  = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_mult = 1'b0;
  logic         start_div = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_zero;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mult_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Result model from plain signed arithmetic
  task automatic model(input bit is_mult, input logic [31:0] oa, input logic [31:0] ob,
                       output logic [31:0] nhi, output logic [31:0] nlo,
                       output logic ndz, output int lat);
    longint pa, pb;
    logic [63:0] p;
    int sa, sb;
    if (is_mult) begin
      pa  = longint'($signed(oa));
      pb  = longint'($signed(ob));
      p   = pa * pb;
      nhi = p[63:32];
      nlo = p[31:0];
      ndz = 1'b0;
      lat = MULT_LAT;
    end else if (ob == 32'd0) begin
      nhi = exp_hi;
      nlo = exp_lo;
      ndz = 1'b1;
      lat = DZ_LAT;
    end else begin
      ndz = 1'b0;
      lat = DIV_LAT;
      if (oa == 32'h8000_0000 && ob == 32'hFFFF_FFFF) begin
        nlo = 32'h8000_0000;
        nhi = 32'd0;
      end else begin
        sa  = $signed(oa);
        sb  = $signed(ob);
        nlo = 32'(sa / sb);
        nhi = 32'(sa % sb);
      end
    end
  endtask

  task automatic run_op(input string tag, input bit do_mult, input bit do_div,
                        input logic [31:0] oa, input logic [31:0] ob, input int pulse_at);
    logic [31:0] nhi, nlo;
    logic ndz;
    int lat, k, extra;
    bit busy_ok, hold_ok;
    model(do_mult, oa, ob, nhi, nlo, ndz, lat);
    @(negedge clk);
    start_mult = do_mult;
    start_div  = do_div;
    a = oa;
    b = ob;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = $urandom;
    b = $urandom;
    k = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (done !== 1'b1 && k < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (hi !== exp_hi || lo !== exp_lo) hold_ok = 1'b0;
      if (k == pulse_at) begin
        start_mult = 1'b1;
        a = $urandom;
        b = $urandom;
      end
      @(negedge clk);
      start_mult = 1'b0;
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(lat));
    check({tag, "_busy_during"}, 64'(busy_ok), 64'(1));
    check({tag, "_hold_hilo"}, 64'(hold_ok), 64'(1));
    check({tag, "_hi"}, 64'(hi), 64'(nhi));
    check({tag, "_lo"}, 64'(lo), 64'(nlo));
    check({tag, "_div_zero"}, 64'(div_zero), 64'(ndz));
    check({tag, "_busy_at_done"}, 64'(busy), 64'(1));
    exp_hi = nhi;
    exp_lo = nlo;
    @(negedge clk);
    check({tag, "_busy_done_after"}, 64'({busy, done}), 64'(0));
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1 || hi !== nhi || lo !== nlo) extra++;
    end
    check({tag, "_quiet_after"}, 64'(extra), 64'(0));
  endtask

  initial begin
    int extra;
    logic [31:0] ra, rb;
    bit m;
    int sel;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_flags", 64'({busy, done, div_zero}), 64'(0));
    reset = 1'b0;

    run_op("tp1_mult", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1);
    check("tp1_hi_const", 64'(hi), 64'(32'hFFFF_FFFF));
    check("tp1_lo_const", 64'(lo), 64'(32'hFFFF_FFEB));

    run_op("tp2_mult_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1);
    check("tp2_hi_const", 64'(hi), 64'(32'h4000_0000));
    check("tp2_lo_const", 64'(lo), 64'(32'h0000_0000));

    run_op("tp3_div_neg", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
    check("tp3_lo_const", 64'(lo), 64'(32'hFFFF_FFFD));
    check("tp3_hi_const", 64'(hi), 64'(32'hFFFF_FFFF));

    run_op("tp4_div_prep", 1'b0, 1'b1, 32'd5, 32'd2, -1);
    run_op("tp4_div_zero", 1'b0, 1'b1, 32'd5, 32'd0, -1);
    check("tp4_hi_kept", 64'(hi), 64'(1));
    check("tp4_lo_kept", 64'(lo), 64'(2));
    check("tp4_dz_held", 64'(div_zero), 64'(1));
    run_op("tp4_mult_clear", 1'b1, 1'b0, 32'd2, 32'd3, -1);

    run_op("tp5_div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check("tp5_lo_const", 64'(lo), 64'(32'h8000_0000));
    check("tp5_hi_const", 64'(hi), 64'(0));

    run_op("both_starts", 1'b1, 1'b1, 32'd6, 32'hFFFF_FFFE, -1);

    // Reset partway through a multiply
    @(negedge clk);
    start_mult = 1'b1;
    a = 32'h1234_5678;
    b = 32'h0000_0FFF;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_flags", 64'({busy, done, div_zero}), 64'(0));
    check("midreset_hi", 64'(hi), 64'(0));
    check("midreset_lo", 64'(lo), 64'(0));
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    check("midreset_no_done", 64'(extra), 64'(0));
    run_op("post_reset_mult", 1'b1, 1'b0, 32'd3, 32'd4, -1);
    check("post_reset_lo", 64'(lo), 64'(12));
    check("post_reset_hi", 64'(hi), 64'(0));

    for (int i = 0; i < 24; i++) begin
      m   = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op("rand", m, !m, ra, rb, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
